// File: rtl/fir_pkg.sv
// Shared widths and sequencer state encoding for the serial FIR datapath.
package fir_pkg;
  localparam int DATA_W       = 18;
  localparam int COEF_W       = 25;
  localparam int ACC_W        = 48;
  localparam int FIR_CELL_LAT = 3;

  typedef enum logic [2:0] {FLUSH, IDLE, RUN, DRAIN, OUT} fir_seq_state_t;
endpackage

// File: rtl/fir_tap_bank.sv
// Sample delay line and coefficient bank: one write port and one async read port each.
module fir_tap_bank #(
  parameter int NTAPS  = 32,
  parameter int DATA_W = 18,
  parameter int COEF_W = 25,
  parameter int AW     = $clog2(NTAPS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              smp_we_i,
  input  logic [AW-1:0]     smp_waddr_i,
  input  logic [DATA_W-1:0] smp_wdata_i,
  input  logic [AW-1:0]     smp_raddr_i,
  output logic [DATA_W-1:0] smp_rdata_o,
  input  logic              coef_we_i,
  input  logic [AW-1:0]     coef_waddr_i,
  input  logic [COEF_W-1:0] coef_wdata_i,
  input  logic [AW-1:0]     coef_raddr_i,
  output logic [COEF_W-1:0] coef_rdata_o
);

  logic [DATA_W-1:0] smp_q  [NTAPS];
  logic [COEF_W-1:0] coef_q [NTAPS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NTAPS; i++) begin
        smp_q[i]  <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      if (smp_we_i) smp_q[smp_waddr_i] <= smp_wdata_i;
      // Addresses past the last tap are dropped when NTAPS is not a power of two.
      if (coef_we_i && (int'(coef_waddr_i) < NTAPS)) coef_q[coef_waddr_i] <= coef_wdata_i;
    end
  end

  assign smp_rdata_o  = smp_q[smp_raddr_i];
  assign coef_rdata_o = coef_q[coef_raddr_i];

endmodule

// File: rtl/fir_mac_sequencer.sv
// Serial FIR controller: time-multiplexes one external MAC cell over NTAPS taps per sample.
module fir_mac_sequencer #(
  parameter int NTAPS  = 32,
  parameter int LAT    = fir_pkg::FIR_CELL_LAT,
  parameter int DATA_W = fir_pkg::DATA_W,
  parameter int COEF_W = fir_pkg::COEF_W,
  parameter int ACC_W  = fir_pkg::ACC_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_W-1:0]        s_data,
  input  logic                     coef_we,
  output logic                     coef_ready,
  input  logic [$clog2(NTAPS)-1:0] coef_addr,
  input  logic [COEF_W-1:0]        coef_wdata,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [ACC_W-1:0]         m_data,
  output logic                     cell_valid_in,
  output logic [COEF_W-1:0]        cell_coef,
  output logic [DATA_W-1:0]        cell_mult,
  output logic [ACC_W-1:0]         cell_acc,
  input  logic                     cell_valid_out,
  input  logic [ACC_W-1:0]         cell_result
);
  import fir_pkg::*;

  localparam int AW = $clog2(NTAPS);
  localparam int CW = $clog2(NTAPS + 1);
  localparam int FW = (LAT > 1) ? $clog2(LAT) : 1;

  fir_seq_state_t   state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    tap_q, tap_d;
  logic [CW-1:0]    ret_cnt_q, ret_cnt_d;
  logic [FW-1:0]    flush_q, flush_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] m_data_q, m_data_d;
  logic             smp_we, coef_wr, run;
  logic [AW-1:0]    rd_idx;
  logic [DATA_W-1:0] smp_rdata;
  logic [COEF_W-1:0] coef_rdata;

  // Tap 0 is the newest sample, so older taps walk backwards around the ring.
  assign rd_idx = (wr_ptr_q >= tap_q) ? (wr_ptr_q - tap_q)
                                      : AW'(int'(wr_ptr_q) + NTAPS - int'(tap_q));

  fir_tap_bank #(
    .NTAPS(NTAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .AW(AW)
  ) u_bank (
    .clk         (clk),
    .reset       (reset),
    .smp_we_i    (smp_we),
    .smp_waddr_i (wr_ptr_q),
    .smp_wdata_i (s_data),
    .smp_raddr_i (rd_idx),
    .smp_rdata_o (smp_rdata),
    .coef_we_i   (coef_wr),
    .coef_waddr_i(coef_addr),
    .coef_wdata_i(coef_wdata),
    .coef_raddr_i(tap_q),
    .coef_rdata_o(coef_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FLUSH;
      wr_ptr_q  <= '0;
      tap_q     <= '0;
      ret_cnt_q <= '0;
      flush_q   <= FW'(LAT - 1);
      acc_q     <= '0;
      m_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      tap_q     <= tap_d;
      ret_cnt_q <= ret_cnt_d;
      flush_q   <= flush_d;
      acc_q     <= acc_d;
      m_data_q  <= m_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    tap_d     = tap_q;
    ret_cnt_d = ret_cnt_q;
    flush_d   = flush_q;
    acc_d     = acc_q;
    m_data_d  = m_data_q;
    smp_we    = 1'b0;
    coef_wr   = 1'b0;
    unique case (state_q)
      FLUSH: begin
        if (flush_q == '0) state_d = IDLE;
        else               flush_d = flush_q - FW'(1);
      end
      IDLE: begin
        coef_wr = coef_we;
        if (s_valid) begin
          smp_we    = 1'b1;
          acc_d     = '0;
          ret_cnt_d = '0;
          tap_d     = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (int'(tap_q) == NTAPS - 1) state_d = DRAIN;
        else                          tap_d   = tap_q + AW'(1);
      end
      DRAIN: ;
      OUT: begin
        if (m_ready) begin
          wr_ptr_d = (int'(wr_ptr_q) == NTAPS - 1) ? '0 : wr_ptr_q + AW'(1);
          state_d  = IDLE;
        end
      end
      default: state_d = FLUSH;
    endcase

    if ((state_q == RUN || state_q == DRAIN) && cell_valid_out) begin
      acc_d     = acc_q + cell_result;
      ret_cnt_d = ret_cnt_q + CW'(1);
    end
    // Capture on the final return itself so the result is valid one cycle later.
    if (state_q == DRAIN && ret_cnt_d == CW'(NTAPS)) begin
      m_data_d = acc_d;
      state_d  = OUT;
    end
  end

  assign run           = (state_q == RUN);
  assign s_ready       = (state_q == IDLE);
  assign coef_ready    = (state_q == IDLE);
  assign m_valid       = (state_q == OUT);
  assign m_data        = m_data_q;
  assign cell_valid_in = run;
  assign cell_mult     = run ? smp_rdata : '0;
  assign cell_coef     = run ? coef_rdata : '0;
  assign cell_acc      = '0;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer with a behavioural 3-stage MAC cell and a result scoreboard.
module tb_fir_mac_sequencer;
  localparam int NTAPS  = 4;
  localparam int LAT    = 3;
  localparam int DATA_W = 18;
  localparam int COEF_W = 25;
  localparam int ACC_W  = 48;
  localparam int AW     = $clog2(NTAPS);

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] s_data = '0;
  logic              coef_we = 1'b0;
  logic              coef_ready;
  logic [AW-1:0]     coef_addr = '0;
  logic [COEF_W-1:0] coef_wdata = '0;
  logic              m_valid;
  logic              m_ready = 1'b1;
  logic [ACC_W-1:0]  m_data;
  logic              cell_valid_in;
  logic [COEF_W-1:0] cell_coef;
  logic [DATA_W-1:0] cell_mult;
  logic [ACC_W-1:0]  cell_acc;
  logic              cell_valid_out;
  logic [ACC_W-1:0]  cell_result;

  int checks = 0;
  int errors = 0;
  logic [ACC_W-1:0] sb [$];

  always #5 clk = ~clk;

  fir_mac_sequencer #(
    .NTAPS(NTAPS), .LAT(LAT), .DATA_W(DATA_W), .COEF_W(COEF_W), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .coef_we(coef_we), .coef_ready(coef_ready), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .cell_valid_in(cell_valid_in), .cell_coef(cell_coef), .cell_mult(cell_mult),
    .cell_acc(cell_acc), .cell_valid_out(cell_valid_out), .cell_result(cell_result)
  );

  // MAC cell model: result = acc_in + mult_in*coef, LAT cycles after valid_in; never reset.
  logic [LAT-1:0] pv = '0;
  logic signed [ACC_W-1:0] pr [LAT];
  always @(posedge clk) begin
    pv    <= {pv[LAT-2:0], cell_valid_in};
    pr[0] <= $signed(cell_acc) + $signed(cell_mult) * $signed(cell_coef);
    for (int i = 1; i < LAT; i++) pr[i] <= pr[i-1];
  end
  assign cell_valid_out = pv[LAT-1];
  assign cell_result    = pr[LAT-1];

  task automatic chk(input string tag, input logic [ACC_W-1:0] obs, input logic [ACC_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && m_valid && m_ready) begin
      if (sb.size() == 0) chk("m_unexpected", 48'(m_data), 48'(1));
      else                chk("m_data", m_data, sb.pop_front());
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!s_ready && n < 100) begin cyc(); n++; end
    if (!s_ready) chk("idle_timeout", 48'(0), 48'(1));
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin cyc(); n++; end
    if (sb.size() != 0) chk("drain_timeout", 48'(sb.size()), 48'(0));
    wait_idle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;
    wait_idle();
  endtask

  task automatic wr_coef(input int addr, input int val);
    wait_idle();
    coef_we = 1'b1; coef_addr = AW'(addr); coef_wdata = COEF_W'(val);
    cyc();
    coef_we = 1'b0;
  endtask

  task automatic load4(input int c0, input int c1, input int c2, input int c3);
    wr_coef(0, c0); wr_coef(1, c1); wr_coef(2, c2); wr_coef(3, c3);
  endtask

  task automatic send(input int x, input longint e);
    wait_idle();
    sb.push_back(ACC_W'(e));
    s_valid = 1'b1; s_data = DATA_W'(x);
    cyc();
    s_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    cyc(); cyc();
    chk("rst_s_ready", 48'(s_ready), 48'(0));
    chk("rst_coef_ready", 48'(coef_ready), 48'(0));
    chk("rst_m_valid", 48'(m_valid), 48'(0));
    chk("rst_m_data", m_data, 48'(0));
    chk("rst_cell_vin", 48'(cell_valid_in), 48'(0));
    chk("rst_cell_coef", 48'(cell_coef), 48'(0));
    chk("rst_cell_mult", 48'(cell_mult), 48'(0));
    reset = 1'b0;
    chk("flush_s_ready", 48'(s_ready), 48'(0));
    wait_idle();

    // Impulse response
    load4(1, 2, 3, 4);
    send(1, 1); drain();
    send(0, 2); drain();
    send(0, 3); drain();
    send(0, 4); drain();
    send(0, 0); drain();

    // Latency and busy window
    do_reset();
    sb.push_back(48'(0));
    s_valid = 1'b1; s_data = DATA_W'(5);
    first = 0;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      s_valid = 1'b0;
      if (c <= 8) chk("busy_s_ready", 48'(s_ready), 48'(0));
      if (m_valid && first == 0) first = c;
    end
    chk("latency", 48'(first), 48'(8));
    drain();

    // Step response
    do_reset();
    load4(1, 2, 3, 4);
    send(100, 100); drain();
    send(100, 300); drain();
    send(100, 600); drain();
    send(100, 1000); drain();

    // Backpressure with a coefficient write attempted while busy
    m_ready = 1'b0;
    send(100, 1000);
    first = 0;
    while (!m_valid && first < 50) begin cyc(); first++; end
    chk("bp_m_valid", 48'(m_valid), 48'(1));
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin coef_we = 1'b1; coef_addr = '0; coef_wdata = COEF_W'(77); end
      chk("bp_m_data", m_data, 48'(1000));
      chk("bp_s_ready", 48'(s_ready), 48'(0));
      chk("bp_coef_ready", 48'(coef_ready), 48'(0));
      cyc();
      coef_we = 1'b0;
    end
    m_ready = 1'b1;
    drain();
    send(1, 901); drain();

    // Extreme operands, steady state reaches 2^43
    do_reset();
    load4(-16777216, -16777216, -16777216, -16777216);
    for (int k = 1; k <= 4; k++) begin
      send(-131072, longint'(k) << 41);
      drain();
    end

    // Reset in the middle of RUN
    do_reset();
    load4(1, 2, 3, 4);
    wait_idle();
    s_valid = 1'b1; s_data = DATA_W'(7);
    cyc();
    s_valid = 1'b0;
    cyc(); cyc();
    chk("mid_run_vin", 48'(cell_valid_in), 48'(1));
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_s_ready", 48'(s_ready), 48'(0));
      chk("post_rst_m_valid", 48'(m_valid), 48'(0));
      cyc();
    end
    send(1, 0); drain();
    load4(1, 2, 3, 4);
    send(0, 2); drain();

    repeat (5) cyc();
    chk("sb_leftover", 48'(sb.size()), 48'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
